// File: rtl/alu_seq.sv
// Registered multicycle ALU with start/done handshake and N/Z/C/V flags.
// Define ALU_ITER_SHIFT_EN to replace the barrel shifter with a one-bit-per-cycle shifter.
module alu_seq #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam logic [2:0] OP_SUB = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             finish;
    logic [WIDTH-1:0] res_c;
    logic             c_c;
    logic             v_c;
    logic [WIDTH:0]   sum_w;

`ifdef ALU_ITER_SHIFT_EN
    logic [SHW-1:0]   cnt;
    logic             carry_reg;
`else
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] rot_w;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start)  state_next = EXEC;
            EXEC: if (finish) state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == EXEC);
    end

    // Shifts in the iterative build stay in EXEC until the remaining count reaches zero.
    always_comb begin
`ifdef ALU_ITER_SHIFT_EN
        finish = (state == EXEC) && (!op_reg[2] || cnt == '0);
`else
        finish = (state == EXEC);
`endif
    end

    always_comb begin
        res_c = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        sum_w = '0;
`ifndef ALU_ITER_SHIFT_EN
        shamt = b_reg[SHW-1:0];
        rot_w = {a_reg, a_reg} >> shamt;
`endif
        case (op_reg)
            OP_SUB: begin
                sum_w = {1'b0, a_reg} + {1'b0, ~b_reg} + {{WIDTH{1'b0}}, 1'b1};
                res_c = sum_w[WIDTH-1:0];
                c_c   = sum_w[WIDTH];
                v_c   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (res_c[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_ADD: begin
                sum_w = {1'b0, a_reg} + {1'b0, b_reg};
                res_c = sum_w[WIDTH-1:0];
                c_c   = sum_w[WIDTH];
                v_c   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (res_c[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_AND: res_c = a_reg & b_reg;
            OP_OR:  res_c = a_reg | b_reg;
            default: begin
`ifdef ALU_ITER_SHIFT_EN
                res_c = a_reg;
                c_c   = carry_reg;
`else
                // An extra guard bit on the shifted-out side captures the last bit lost.
                if (shamt == '0) begin
                    res_c = a_reg;
                end else begin
                    case (op_reg[1:0])
                        2'b00: {c_c, res_c} = {1'b0, a_reg} << shamt;
                        2'b01: {res_c, c_c} = {a_reg, 1'b0} >> shamt;
                        2'b10: {res_c, c_c} = $signed({a_reg, 1'b0}) >>> shamt;
                        default: begin
                            res_c = rot_w[WIDTH-1:0];
                            c_c   = rot_w[WIDTH-1];
                        end
                    endcase
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done   <= 1'b0;
            result <= '0;
            flags  <= '0;
            op_reg <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
`ifdef ALU_ITER_SHIFT_EN
            cnt       <= '0;
            carry_reg <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                op_reg <= op;
                a_reg  <= a_in;
                b_reg  <= b_in;
`ifdef ALU_ITER_SHIFT_EN
                cnt       <= b_in[SHW-1:0];
                carry_reg <= 1'b0;
`endif
            end else if (finish) begin
                result <= res_c;
                flags  <= {res_c[WIDTH-1], (res_c == '0), c_c, v_c};
                done   <= 1'b1;
            end
`ifdef ALU_ITER_SHIFT_EN
            else if (state == EXEC) begin
                // One bit per cycle; a_reg doubles as the shift accumulator.
                case (op_reg[1:0])
                    2'b00:   {carry_reg, a_reg} <= {a_reg, 1'b0};
                    2'b01:   {a_reg, carry_reg} <= {1'b0, a_reg};
                    2'b10:   {a_reg, carry_reg} <= {a_reg[WIDTH-1], a_reg};
                    default: {a_reg, carry_reg} <= {a_reg[0], a_reg};
                endcase
                cnt <= cnt - 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16) against a bit-serial reference model.
module tb_alu_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  flags;

    int checks;
    int errors;

    alu_seq #(.WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .result(result),
        .flags (flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: returns {N,Z,C,V,result}
    function automatic logic [19:0] model(input logic [2:0] m_op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        c;
        logic        v;
        int          sa;
        int          sb;
        int          sr;
        int          s;
        r  = '0;
        c  = 1'b0;
        v  = 1'b0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (m_op)
            3'd0: begin
                r  = a - b;
                c  = (a >= b);
                sr = sa - sb;
                v  = (sr > 32767) || (sr < -32768);
            end
            3'd1: begin
                r  = a + b;
                c  = (int'(a) + int'(b)) > 65535;
                sr = sa + sb;
                v  = (sr > 32767) || (sr < -32768);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            default: begin
                r = a;
                s = int'(b[3:0]);
                for (int i = 0; i < s; i++) begin
                    case (m_op)
                        3'd4: begin c = r[15]; r = r * 2; end
                        3'd5: begin c = r[0];  r = r / 2; end
                        3'd6: begin c = r[0];  r = {r[15], r[15:1]}; end
                        default: begin c = r[0]; r = {r[0], r[15:1]}; end
                    endcase
                end
            end
        endcase
        return {r[15], (r == 16'h0000), c, v, r};
    endfunction

    function automatic int exp_lat(input logic [2:0] m_op, input logic [15:0] b);
`ifdef ALU_ITER_SHIFT_EN
        if (m_op[2]) return 1 + int'(b[3:0]);
`endif
        return 1;
    endfunction

    // Drives one request and waits (bounded) for done; lat=-1 on timeout.
    task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic [3:0] f, output int lat, output logic bk);
        @(negedge clock);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        @(posedge clock);
        #1;
        bk    = busy;
        start = 1'b0;
        a_in  = 16'($urandom);
        b_in  = 16'($urandom);
        op    = 3'($urandom);
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        r = result;
        f = flags;
    endtask

    task automatic test_reset();
        logic [15:0] r;
        logic [3:0]  f;
        int          lat;
        logic        bk;
        reset = 1'b1;
        start = 1'b1;
        op    = 3'd1;
        a_in  = 16'h1111;
        b_in  = 16'h2222;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (result !== 16'h0000 || flags !== 4'h0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_state: result=%h flags=%b done=%b busy=%b, want 0000 0000 0 0", result, flags, done, busy);
            end
        end
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        run_op(3'd1, 16'h0003, 16'h0004, r, f, lat, bk);
        checks++;
        if (r !== 16'h0007 || f !== 4'b0000 || lat !== 1) begin
            errors++;
            $display("[TB] FAIL first_op: result=%h flags=%b lat=%0d, want 0007 0000 1", r, f, lat);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  d_op [8];
        logic [15:0] d_a  [8];
        logic [15:0] d_b  [8];
        logic [15:0] d_r  [8];
        logic [3:0]  d_f  [8];
        logic [15:0] r;
        logic [3:0]  f;
        int          lat;
        logic        bk;
        d_op = '{3'd1,     3'd0,     3'd6,     3'd7,     3'd7,     3'd2,     3'd3,     3'd4};
        d_a  = '{16'h7FFF, 16'h0005, 16'h8010, 16'h0001, 16'h1234, 16'hF0F0, 16'hF000, 16'h8001};
        d_b  = '{16'h0001, 16'h0005, 16'h0004, 16'h0001, 16'h0000, 16'h0FF0, 16'h000F, 16'h0001};
        d_r  = '{16'h8000, 16'h0000, 16'hF801, 16'h8000, 16'h1234, 16'h00F0, 16'hF00F, 16'h0002};
        d_f  = '{4'b1001,  4'b0110,  4'b1000,  4'b1010,  4'b0000,  4'b0000,  4'b1000,  4'b0010};
        for (int i = 0; i < 8; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], r, f, lat, bk);
            checks++;
            if (r !== d_r[i] || f !== d_f[i]) begin
                errors++;
                $display("[TB] FAIL directed_%0d: result=%h flags=%b, want %h %b", i, r, f, d_r[i], d_f[i]);
            end
            checks++;
            if (lat !== exp_lat(d_op[i], d_b[i]) || bk !== 1'b1) begin
                errors++;
                $display("[TB] FAIL directed_lat_%0d: lat=%0d busy=%b, want %0d 1", i, lat, bk, exp_lat(d_op[i], d_b[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [15:0] a;
        logic [15:0] b;
        logic [19:0] exp;
        logic [15:0] r;
        logic [3:0]  f;
        int          lat;
        logic        bk;
        for (int i = 0; i < 60; i++) begin
            o   = 3'($urandom);
            a   = 16'($urandom);
            b   = 16'($urandom);
            exp = model(o, a, b);
            run_op(o, a, b, r, f, lat, bk);
            checks++;
            if ({f, r} !== exp || lat !== exp_lat(o, b) || bk !== 1'b1) begin
                errors++;
                $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: flags/result=%b/%h lat=%0d, want %b/%h lat=%0d",
                         i, o, a, b, f, r, lat, exp[19:16], exp[15:0], exp_lat(o, b));
            end
        end
    endtask

    task automatic test_hold();
        logic [15:0] r;
        logic [3:0]  f;
        int          lat;
        logic        bk;
        run_op(3'd2, 16'hF0F0, 16'h0FF0, r, f, lat, bk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            a_in = 16'($urandom);
            b_in = 16'($urandom);
            @(posedge clock);
            #1;
            checks++;
            if (result !== 16'h00F0 || flags !== 4'b0000 || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_%0d: result=%h flags=%b done=%b, want 00f0 0000 0", i, result, flags, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        start = 1'b1;
        op    = 3'd1;
        a_in  = 16'h0001;
        b_in  = 16'h0001;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (done !== 1'(i % 2) || busy !== 1'(1 - i % 2)) begin
                errors++;
                $display("[TB] FAIL b2b_cycle_%0d: done=%b busy=%b, want %0d %0d", i, done, busy, i % 2, 1 - i % 2);
            end
            if (done === 1'b1) begin
                checks++;
                if (result !== 16'h0002 || flags !== 4'b0000) begin
                    errors++;
                    $display("[TB] FAIL b2b_result_%0d: result=%h flags=%b, want 0002 0000", i, result, flags);
                end
            end
        end
        start = 1'b0;
        @(posedge clock);
    endtask

    task automatic test_reset_abort();
        int          dones;
        int          exp_dones;
        logic [15:0] r;
        logic [3:0]  f;
        int          lat;
        logic        bk;
`ifdef ALU_ITER_SHIFT_EN
        exp_dones = 0;
`else
        exp_dones = 1;
`endif
        dones = 0;
        @(negedge clock);
        start = 1'b1;
        op    = 3'd4;
        a_in  = 16'h0001;
        b_in  = 16'h000F;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) dones++;
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        if (done === 1'b1) dones++;
        checks++;
        if (dones !== exp_dones || result !== 16'h0000 || flags !== 4'h0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort: dones=%0d result=%h flags=%b busy=%b, want %0d 0000 0000 0", dones, result, flags, busy, exp_dones);
        end
        @(negedge clock);
        reset = 1'b0;
        run_op(3'd0, 16'h000A, 16'h0003, r, f, lat, bk);
        checks++;
        if (r !== 16'h0007 || f !== 4'b0010 || lat !== 1) begin
            errors++;
            $display("[TB] FAIL after_abort: result=%h flags=%b lat=%0d, want 0007 0010 1", r, f, lat);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        a_in   = '0;
        b_in   = '0;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
